// File: rtl/cmos_capture_565_pkg.sv
// Shared video geometry defaults and capture FSM encodings for the DVP
// capture path.
package cmos_capture_565_pkg;

  localparam int VID_H_ACTIVE     = 640;
  localparam int VID_V_ACTIVE     = 480;
  localparam int CMOS_SKIP_FRAMES = 10;

  localparam logic [1:0] ST_WAIT_VS_ENC  = 2'd0;
  localparam logic [1:0] ST_SKIP_ENC     = 2'd1;
  localparam logic [1:0] ST_CAPTURE_ENC  = 2'd2;

  typedef enum logic [1:0] {
    ST_WAIT_VS = ST_WAIT_VS_ENC,
    ST_SKIP    = ST_SKIP_ENC,
    ST_CAPTURE = ST_CAPTURE_ENC
  } cap_state_t;

  // Skip counter must hold SKIP_FRAMES itself; never collapse to zero width.
  function automatic int skip_cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/cmos_byte_pack.sv
// Pairs sensor bytes into 16-bit pixels and counts words per line,
// saturating the column count at H_ACTIVE.
module cmos_byte_pack
  import cmos_capture_565_pkg::*;
#(
  parameter int H_ACTIVE      = VID_H_ACTIVE,
  parameter bit HI_BYTE_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_href,
  input  logic        i_clear,
  output logic [15:0] o_word,
  output logic        o_word_valid,
  output logic [15:0] o_x,
  output logic        o_phase
);

  localparam logic [15:0] H_LIM = 16'(H_ACTIVE);

  logic        r_phase;
  logic [7:0]  r_byte;
  logic [15:0] r_word;
  logic [15:0] r_x;
  logic        r_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= 1'b0;
      r_byte  <= '0;
      r_word  <= '0;
      r_x     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_clear) begin
        r_phase <= 1'b0;
        r_x     <= '0;
      end else if (i_href) begin
        if (!r_phase) begin
          r_byte  <= i_data;
          r_phase <= 1'b1;
        end else begin
          r_phase <= 1'b0;
          // Words past the line width are dropped; wr_data holds the last pixel.
          if (r_x < H_LIM) begin
            r_word  <= HI_BYTE_FIRST ? {r_byte, i_data} : {i_data, r_byte};
            r_valid <= 1'b1;
            r_x     <= r_x + 16'd1;
          end
        end
      end
    end
  end

  assign o_word       = r_word;
  assign o_word_valid = r_valid;
  assign o_x          = r_x;
  assign o_phase      = r_phase;

endmodule

// File: rtl/cmos_capture_565.sv
// DVP sensor capture: skips settling frames, crops to H_ACTIVE x V_ACTIVE and
// writes RGB565 words plus frame markers to the frame buffer write port.
module cmos_capture_565
  import cmos_capture_565_pkg::*;
#(
  parameter int H_ACTIVE       = VID_H_ACTIVE,
  parameter int V_ACTIVE       = VID_V_ACTIVE,
  parameter int SKIP_FRAMES    = CMOS_SKIP_FRAMES,
  parameter bit VSYNC_ACT_HIGH = 1'b1,
  parameter bit HI_BYTE_FIRST  = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmos_vsync,
  input  logic        cmos_href,
  input  logic [7:0]  cmos_data,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        wr_frame_sync,
  output logic        frame_error
);

  localparam int             SKW      = skip_cnt_w(SKIP_FRAMES);
  localparam logic [SKW-1:0] SKIP_LIM = SKW'(SKIP_FRAMES);
  localparam logic [15:0]    H_LIM    = 16'(H_ACTIVE);
  localparam logic [15:0]    V_LIM    = 16'(V_ACTIVE);
  localparam logic           VS_IDLE  = ~VSYNC_ACT_HIGH;

  logic           r_vs1, r_vs2, r_href1, r_href2;
  logic [7:0]     r_data1;
  cap_state_t     r_state, w_state_next;
  logic [SKW-1:0] r_skip_cnt;
  logic [15:0]    r_y, w_y_closed;
  logic           r_err, w_err_closed;

  logic           w_vs_act1, w_vs_act2, w_frame_start, w_frame_end;
  logic           w_capture, w_href_fall, w_line_close, w_start_cap;
  logic [15:0]    w_word, w_x;
  logic           w_word_valid, w_phase;

  // Sync registers idle at the blanking-inactive level so reset creates no edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vs1   <= VS_IDLE;
      r_vs2   <= VS_IDLE;
      r_href1 <= 1'b0;
      r_href2 <= 1'b0;
      r_data1 <= '0;
    end else begin
      r_vs1   <= cmos_vsync;
      r_vs2   <= r_vs1;
      r_href1 <= cmos_href;
      r_href2 <= r_href1;
      r_data1 <= cmos_data;
    end
  end

  assign w_vs_act1     = (r_vs1 == VSYNC_ACT_HIGH);
  assign w_vs_act2     = (r_vs2 == VSYNC_ACT_HIGH);
  assign w_frame_start = w_vs_act2 & ~w_vs_act1;
  assign w_frame_end   = ~w_vs_act2 & w_vs_act1;
  assign w_capture     = (r_state == ST_CAPTURE);
  assign w_href_fall   = r_href2 & ~r_href1;
  // A vsync arriving mid-line closes that line before the frame is judged.
  assign w_line_close  = w_capture & (w_href_fall | (w_frame_end & r_href1));
  assign w_start_cap   = w_frame_start & (w_state_next == ST_CAPTURE);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_WAIT_VS: if (w_frame_start) w_state_next = (SKIP_FRAMES == 0) ? ST_CAPTURE : ST_SKIP;
      ST_SKIP:    if (w_frame_start && (r_skip_cnt >= SKIP_LIM)) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_CAPTURE;
      default:    w_state_next = ST_WAIT_VS;
    endcase
  end

  always_comb begin
    w_y_closed   = r_y;
    w_err_closed = r_err;
    if (w_line_close) begin
      if ((w_x != '0) && (r_y < V_LIM)) w_y_closed = r_y + 16'd1;
      if (w_phase || ((w_x != '0) && (w_x < H_LIM))) w_err_closed = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_WAIT_VS;
      r_skip_cnt <= '0;
      r_y        <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if ((r_state == ST_SKIP) && w_frame_end && (r_skip_cnt < SKIP_LIM))
        r_skip_cnt <= r_skip_cnt + SKW'(1);
      r_y   <= w_start_cap ? 16'd0 : w_y_closed;
      r_err <= (w_capture & w_frame_end) ? 1'b0 : w_err_closed;
    end
  end

  cmos_byte_pack #(
    .H_ACTIVE      (H_ACTIVE),
    .HI_BYTE_FIRST (HI_BYTE_FIRST)
  ) u_pack (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_data       (r_data1),
    .i_href       (w_capture & r_href1 & ~w_vs_act1),
    .i_clear      (w_start_cap | w_line_close),
    .o_word       (w_word),
    .o_word_valid (w_word_valid),
    .o_x          (w_x),
    .o_phase      (w_phase)
  );

  assign wr_en         = w_word_valid & w_capture & (r_y < V_LIM);
  assign wr_data       = w_word;
  assign wr_frame_sync = w_start_cap;
  assign frame_error   = w_capture & w_frame_end & (w_err_closed | (w_y_closed != V_LIM));

endmodule

// File: tb/tb_cmos_capture_565.sv
// Scoreboard bench: stimulus queues expected outputs, a monitor pops and
// compares whenever the capture block presents a write, sync or error.
module tb_cmos_capture_565;

  localparam int K_WORD = 0;
  localparam int K_SYNC = 1;
  localparam int K_ERR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vsync = 1'b0;
  logic        href = 1'b0;
  logic [7:0]  data = 8'h00;

  logic        en_hi, fs_hi, fe_hi, en_lo, fs_lo, fe_lo;
  logic [15:0] wd_hi, wd_lo;

  always #5 clk = ~clk;

  cmos_capture_565 #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(1),
                     .VSYNC_ACT_HIGH(1'b1), .HI_BYTE_FIRST(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
    .wr_en(en_hi), .wr_data(wd_hi), .wr_frame_sync(fs_hi), .frame_error(fe_hi));

  cmos_capture_565 #(.H_ACTIVE(4), .V_ACTIVE(2), .SKIP_FRAMES(1),
                     .VSYNC_ACT_HIGH(1'b1), .HI_BYTE_FIRST(1'b0)) dut_lo (
    .clk(clk), .rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .cmos_data(data),
    .wr_en(en_lo), .wr_data(wd_lo), .wr_frame_sync(fs_lo), .frame_error(fe_lo));

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  ev_t         q_hi[$];
  logic [15:0] q_lo[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic        prev_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int kind, input logic [15:0] val, input string name);
    ev_t e;
    if (q_hi.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got unexpected event (data %h), expected none", name, val);
    end else begin
      e = q_hi.pop_front();
      check({name, "_kind"}, 16'(kind), 16'(e.kind));
      if (kind == K_WORD) check(name, val, e.val);
    end
  endtask

  // Monitor: one printed line per observed transaction.
  always begin
    @(posedge clk);
    #1;
    if (en_hi) begin
      $display("[%0t] wr_en   data=%h", $time, wd_hi);
      check("wr_en_gap", {15'd0, prev_en}, 16'd0);
      pop_check(K_WORD, wd_hi, "word");
    end
    if (fs_hi) begin
      $display("[%0t] wr_frame_sync", $time);
      pop_check(K_SYNC, 16'd0, "frame_sync");
    end
    if (fe_hi) begin
      $display("[%0t] frame_error", $time);
      pop_check(K_ERR, 16'd0, "frame_error");
    end
    prev_en = en_hi;
    if (en_lo) begin
      $display("[%0t] wr_en_lo data=%h", $time, wd_lo);
      if (q_lo.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL word_lo: got unexpected word %h, expected none", wd_lo);
      end else begin
        check("word_lo", wd_lo, q_lo.pop_front());
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      href = 1'b0;
      data = 8'h00;
    end
  endtask

  task automatic vsync_on(input bit exp_err);
    @(negedge clk);
    vsync = 1'b1;
    href  = 1'b0;
    if (exp_err) q_hi.push_back(ev_t'{kind: K_ERR, val: 16'd0});
    idle(4);
  endtask

  task automatic vsync_off(input bit exp_sync);
    @(negedge clk);
    vsync = 1'b0;
    if (exp_sync) q_hi.push_back(ev_t'{kind: K_SYNC, val: 16'd0});
    idle(3);
  endtask

  // Bytes are 1..n, or alternating AA/BB; the first 'emit' pairs are expected.
  task automatic send_bytes(input int n, input int emit, input bit alt);
    logic [7:0] b;
    logic [7:0] prev;
    prev = 8'h00;
    for (int i = 0; i < n; i++) begin
      b = alt ? ((i % 2 == 1) ? 8'hBB : 8'hAA) : 8'(i + 1);
      @(negedge clk);
      href = 1'b1;
      data = b;
      if ((i % 2 == 1) && (i / 2 < emit)) begin
        q_hi.push_back(ev_t'{kind: K_WORD, val: {prev, b}});
        q_lo.push_back({b, prev});
      end
      prev = b;
    end
  endtask

  task automatic send_line(input int n, input int emit, input bit alt);
    send_bytes(n, emit, alt);
    idle(4);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"}, {15'd0, en_hi}, 16'd0);
    check({tag, "_wr_data"}, wd_hi, 16'd0);
    check({tag, "_frame_sync"}, {15'd0, fs_hi}, 16'd0);
    check({tag, "_frame_error"}, {15'd0, fe_hi}, 16'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Partial frame 0 and skipped frame 1: nothing forwarded.
    send_line(8, 0, 1'b0);
    vsync_on(1'b0);
    vsync_off(1'b0);
    send_line(8, 0, 1'b0);
    send_line(8, 0, 1'b0);
    vsync_on(1'b0);

    // Frame 2: first captured frame, 2 lines x 4 words.
    vsync_off(1'b1);
    send_line(8, 4, 1'b0);
    send_line(8, 4, 1'b0);
    vsync_on(1'b0);

    // Cropping: 12-byte lines, 3 lines; third line suppressed.
    vsync_off(1'b1);
    send_line(12, 4, 1'b0);
    send_line(12, 4, 1'b0);
    send_line(12, 0, 1'b0);
    vsync_on(1'b0);

    // Short frame: one line only.
    vsync_off(1'b1);
    send_line(8, 4, 1'b0);
    vsync_on(1'b1);

    // Odd line: 7 bytes, last byte dropped.
    vsync_off(1'b1);
    send_line(8, 4, 1'b0);
    send_line(7, 3, 1'b0);
    vsync_on(1'b1);

    // Byte order: AA,BB -> AABB (hi first) and BBAA (lo first).
    vsync_off(1'b1);
    send_line(8, 4, 1'b1);
    send_line(8, 4, 1'b0);
    vsync_on(1'b0);

    // Reset mid-line after 3 words.
    vsync_off(1'b1);
    send_bytes(7, 3, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    href  = 1'b0;
    data  = 8'h00;
    #1;
    check_idle_outputs("midline_reset");
    idle(3);
    rst_n = 1'b1;
    idle(3);
    vsync_on(1'b0);
    vsync_off(1'b0);
    send_line(8, 0, 1'b0);
    vsync_on(1'b0);
    vsync_off(1'b1);
    send_line(8, 4, 1'b1);
    send_line(8, 4, 1'b0);
    vsync_on(1'b0);

    idle(10);
    check("pending_hi", 16'(q_hi.size()), 16'd0);
    check("pending_lo", 16'(q_lo.size()), 16'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
